simon_key_schedule: RTL

Round-key expansion and storage stage that sits directly downstream of `SIMON_control`'s key path. On a `loadKEY` pulse it captures the M-word master key, expands it into all T round keys one word per cycle, and holds them in a T-entry register buffer. The round datapath reads the buffer by round index; decryption uses the same buffer read in reverse order.

---
 rtl/simon_pkg.sv | 46 ++++
 rtl/simon_key_round.sv | 27 ++
 rtl/simon_key_schedule.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared SIMON definitions: z-sequences, key-schedule state encoding and the
// standard (N,M,T,J) parameter sets.
package simon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } key_state_t;

    typedef struct packed {
        int unsigned n;
        int unsigned m;
        int unsigned t;
        int unsigned j;
    } simon_cfg_t;

    localparam int NUM_CFGS = 10;

    localparam simon_cfg_t SIMON_CFGS [NUM_CFGS] = '{
        '{16, 4, 32, 0},
        '{24, 3, 36, 0},
        '{24, 4, 36, 1},
        '{32, 3, 42, 2},
        '{32, 4, 44, 3},
        '{48, 2, 52, 2},
        '{48, 3, 54, 3},
        '{64, 2, 68, 2},
        '{64, 3, 69, 3},
        '{64, 4, 72, 4}
    };

    // Written exactly as published, so sequence bit 0 is the literal's MSB.
    localparam logic [61:0] Z_SEQ [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    function automatic logic z_bit(input logic [61:0] z, input logic [5:0] idx);
        return z[6'd61 - idx];
    endfunction

endpackage

// File: rtl/simon_key_round.sv
// One step of the SIMON key expansion: derives k[i] from k[i-1], k[i-3],
// k[i-M] and the current z-sequence bit.
module simon_key_round #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic [N-1:0] i_km1,
    input  logic [N-1:0] i_km3,
    input  logic [N-1:0] i_kmM,
    input  logic         i_z,
    output logic [N-1:0] o_next
);

    localparam logic [N-1:0] C = {{(N-2){1'b1}}, 2'b00};

    logic [N-1:0] w_tmp;

    always_comb begin
        w_tmp = {i_km1[2:0], i_km1[N-1:3]};
        if (M == 4) begin
            w_tmp = w_tmp ^ i_km3;
        end
        w_tmp  = w_tmp ^ {w_tmp[0], w_tmp[N-1:1]};
        o_next = C ^ {{(N-1){1'b0}}, i_z} ^ i_kmM ^ w_tmp;
    end

endmodule

// File: rtl/simon_key_schedule.sv
// SIMON round-key expansion and storage: captures the master key on loadKEY,
// expands one word per cycle into a T-entry buffer and serves registered reads.
module simon_key_schedule
    import simon_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32,
    parameter int J = 0
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                loadKEY,
    input  logic [M-1:0][N-1:0] KEY,
    input  logic [7:0]          rdIDX,
    output logic [N-1:0]        rKEY,
    output logic                keyBUSY,
    output logic                keyREADY,
    output logic                keyDONE
);

    generate
        if (T > 255 || T <= M) begin : g_bad_t
            $error("simon_key_schedule: T must satisfy M < T <= 255");
        end
        if (M < 2 || M > 4) begin : g_bad_m
            $error("simon_key_schedule: M must be 2, 3 or 4");
        end
        if (J < 0 || J > 4) begin : g_bad_j
            $error("simon_key_schedule: J must be 0 to 4");
        end
    endgenerate

    localparam int          IW    = (T > 1) ? $clog2(T) : 1;
    localparam logic [7:0]  T8    = 8'(T);
    localparam logic [7:0]  M8    = 8'(M);
    localparam logic [7:0]  LAST8 = 8'(T - 1);
    localparam logic [61:0] ZJ    = Z_SEQ[J];

    key_state_t   r_state;
    key_state_t   w_nextState;
    logic [7:0]   r_idx;
    logic [5:0]   r_zIdx;
    logic [N-1:0] r_buf [T];
    logic         r_done;

    logic         w_last;
    logic         w_z;
    logic [7:0]   w_i1;
    logic [7:0]   w_i3;
    logic [7:0]   w_iM;
    logic [N-1:0] w_km1;
    logic [N-1:0] w_km3;
    logic [N-1:0] w_kmM;
    logic [N-1:0] w_next;

    assign w_last = (r_state == EXPAND) && (r_idx == LAST8);
    assign w_z    = z_bit(ZJ, r_zIdx);

    always_comb begin
        w_nextState = r_state;
        if (loadKEY) begin
            w_nextState = EXPAND;
        end else if (w_last) begin
            w_nextState = READY;
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A load during the final expansion edge restarts the run, so it also suppresses keyDONE.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_idx  <= '0;
            r_zIdx <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last && !loadKEY;
            if (loadKEY) begin
                r_idx  <= M8;
                r_zIdx <= '0;
            end else if (r_state == EXPAND) begin
                r_idx  <= r_idx + 8'd1;
                r_zIdx <= (r_zIdx == 6'd61) ? 6'd0 : r_zIdx + 6'd1;
            end
        end
    end

    always_comb begin
        w_i1  = r_idx - 8'd1;
        w_i3  = r_idx - 8'd3;
        w_iM  = r_idx - M8;
        w_km1 = (w_i1 < T8) ? r_buf[w_i1[IW-1:0]] : '0;
        w_km3 = (M == 4 && w_i3 < T8) ? r_buf[w_i3[IW-1:0]] : '0;
        w_kmM = (w_iM < T8) ? r_buf[w_iM[IW-1:0]] : '0;
    end

    simon_key_round #(
        .N(N),
        .M(M)
    ) u_round (
        .i_km1 (w_km1),
        .i_km3 (w_km3),
        .i_kmM (w_kmM),
        .i_z   (w_z),
        .o_next(w_next)
    );

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            for (int k = 0; k < T; k++) begin
                r_buf[k] <= '0;
            end
        end else if (loadKEY) begin
            for (int k = 0; k < M; k++) begin
                r_buf[k] <= KEY[k];
            end
        end else if (r_state == EXPAND) begin
            r_buf[r_idx[IW-1:0]] <= w_next;
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            rKEY <= '0;
        end else begin
            rKEY <= (rdIDX < T8) ? r_buf[rdIDX[IW-1:0]] : '0;
        end
    end

    assign keyBUSY  = (r_state == EXPAND);
    assign keyREADY = (r_state == READY);
    assign keyDONE  = r_done;

endmodule
